// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two EX-stage requesters and the shared ALU arbiter.
// Port 0 is the integer execute path; port 1 is the address-generation / branch-compare path.
interface alu_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [DATA_WIDTH-1:0]    req_a0;
    logic [DATA_WIDTH-1:0]    req_b0;
    logic [OPCODE_LENGTH-1:0] req_op0;
    logic [DATA_WIDTH-1:0]    req_a1;
    logic [DATA_WIDTH-1:0]    req_b1;
    logic [OPCODE_LENGTH-1:0] req_op1;
    logic [1:0]               rsp_valid;
    logic [1:0]               rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_data;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute-stage ALU between two requesters, with a
// one-entry registered response stage routed back to the issuing port.
module alu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);
    always_comb begin
        ALUResult = '0;
        case (Operation)
            OPCODE_LENGTH'(4'b0000): ALUResult = SrcA & SrcB;
            OPCODE_LENGTH'(4'b0001): ALUResult = SrcA | SrcB;
            OPCODE_LENGTH'(4'b0010): ALUResult = SrcA + SrcB;
            OPCODE_LENGTH'(4'b0011): ALUResult = SrcA ^ SrcB;
            OPCODE_LENGTH'(4'b0100): ALUResult = SrcA << SrcB;
            OPCODE_LENGTH'(4'b0101): ALUResult = SrcA >> SrcB;
            OPCODE_LENGTH'(4'b0110): ALUResult = SrcA - SrcB;
            // SrcA is unsigned, so the arithmetic shift fills with zeros
            OPCODE_LENGTH'(4'b0111): ALUResult = SrcA >>> SrcB;
            OPCODE_LENGTH'(4'b1000): ALUResult = DATA_WIDTH'(SrcA == SrcB);
            OPCODE_LENGTH'(4'b1100): ALUResult = DATA_WIDTH'(SrcA < SrcB);
            default:                 ALUResult = '0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic                     out_port;
    logic                     last_grant;
    logic [DATA_WIDTH-1:0]    data_q;

    logic                     drain;
    logic                     can_issue;
    logic [1:0]               grant;
    logic                     fire;
    logic                     win;
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [OPCODE_LENGTH-1:0] op;
    logic [DATA_WIDTH-1:0]    alu_result;

    always_comb begin
        drain     = 1'b0;
        can_issue = 1'b0;
        grant     = '0;
        state_nxt = state;

        // A held response frees the stage in the same cycle it is accepted.
        drain     = (state == FULL) && bus.rsp_ready[out_port];
        can_issue = (state == EMPTY) || drain;

        if (can_issue && !reset) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end

        fire = |grant;
        win  = grant[1];

        if (fire) begin
            state_nxt = FULL;
        end else if (drain) begin
            state_nxt = EMPTY;
        end

        bus.req_ready = grant;
        bus.rsp_valid = {(state == FULL) && out_port, (state == FULL) && !out_port};
    end

    always_comb begin
        src_a = win ? bus.req_a1  : bus.req_a0;
        src_b = win ? bus.req_b1  : bus.req_b0;
        op    = win ? bus.req_op1 : bus.req_op0;
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .SrcA      (src_a),
        .SrcB      (src_b),
        .Operation (op),
        .ALUResult (alu_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_port   <= 1'b0;
            last_grant <= 1'b1;
            data_q     <= '0;
        end else if (fire) begin
            out_port   <= win;
            last_grant <= win;
            data_q     <= alu_result;
        end
    end

    assign bus.rsp_data = data_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: accepted requests queue their expected
// result; a negedge monitor checks each presented response against the queue head.
module tb_alu_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t q[$];
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_ops(input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [OW-1:0] op0,
                           input logic [DW-1:0] e0, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                           input logic [OW-1:0] op1, input logic [DW-1:0] e1);
        bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0; exp0 = e0;
        bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1; exp1 = e1;
    endtask

    // Entered at posedge+1: drive, check at negedge, record accepted requests, advance.
    task automatic cycle(input logic [1:0] v, input logic [1:0] rr, input logic [1:0] er, input logic [1:0] ev);
        exp_t e;
        bus.req_valid = v;
        bus.rsp_ready = rr;
        @(negedge clk);
        chk("req_ready", DW'(bus.req_ready), DW'(er));
        chk("rsp_valid", DW'(bus.rsp_valid), DW'(ev));
        if (bus.req_ready[0] && v[0]) begin e.port = 1'b0; e.data = exp0; q.push_back(e); end
        if (bus.req_ready[1] && v[1]) begin e.port = 1'b1; e.data = exp1; q.push_back(e); end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid != 2'b00) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: rsp_valid=%b data=0x%08h expected=no response", bus.rsp_valid, bus.rsp_data);
            end else begin
                chk("rsp_port", DW'(bus.rsp_valid[1]), DW'(q[0].port));
                chk("rsp_data", bus.rsp_data, q[0].data);
                if (bus.rsp_ready[bus.rsp_valid[1]]) void'(q.pop_front());
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        set_ops('0, '0, '0, '0, '0, '0, '0, '0);
        @(posedge clk);
        #1;
        chk("reset_req_ready", DW'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", DW'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_data", bus.rsp_data, 32'd0);
        reset = 1'b0;

        // single port-0 ADD 5+7
        set_ops(32'd5, 32'd7, 4'b0010, 32'd12, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b00);
        cycle(2'b00, 2'b11, 2'b00, 2'b01);

        // both ports contending from reset: grants alternate 0,1,0,1
        do_reset();
        set_ops(32'd1, 32'd1, 4'b0010, 32'd2, 32'd10, 32'd3, 4'b0110, 32'd7);
        cycle(2'b11, 2'b11, 2'b01, 2'b00);
        cycle(2'b11, 2'b11, 2'b10, 2'b01);
        cycle(2'b11, 2'b11, 2'b01, 2'b10);
        cycle(2'b11, 2'b11, 2'b10, 2'b01);
        cycle(2'b00, 2'b11, 2'b00, 2'b10);
        cycle(2'b00, 2'b11, 2'b00, 2'b00);

        // port-1 LT held under back-pressure; rsp_ready[0] must not drain it
        set_ops(32'h0000_FF00, 32'h0000_0FF0, 4'b0000, 32'h0000_0F00, 32'd3, 32'd9, 4'b1100, 32'd1);
        cycle(2'b10, 2'b11, 2'b10, 2'b00);
        cycle(2'b01, 2'b01, 2'b00, 2'b10);
        cycle(2'b01, 2'b01, 2'b00, 2'b10);
        cycle(2'b01, 2'b01, 2'b00, 2'b10);
        cycle(2'b01, 2'b11, 2'b01, 2'b10);
        cycle(2'b00, 2'b11, 2'b00, 2'b01);
        cycle(2'b00, 2'b11, 2'b00, 2'b00);

        // back-to-back port-0 op coverage
        set_ops(32'h8000_0000, 32'd4, 4'b0111, 32'h0800_0000, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b00);
        set_ops(32'h1234_5678, 32'd9, 4'b1111, 32'd0, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        set_ops(32'hF0F0_F0F0, 32'hFFFF_FFFF, 4'b0011, 32'h0F0F_0F0F, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        set_ops(32'd1, 32'd4, 4'b0100, 32'd16, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        set_ops(32'd5, 32'd5, 4'b1000, 32'd1, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        set_ops(32'd3, 32'd5, 4'b0110, 32'hFFFF_FFFE, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        set_ops(32'd1, 32'd40, 4'b0100, 32'd0, '0, '0, '0, '0);
        cycle(2'b01, 2'b11, 2'b01, 2'b01);
        cycle(2'b00, 2'b11, 2'b00, 2'b01);
        cycle(2'b00, 2'b11, 2'b00, 2'b00);

        // asynchronous reset while FULL discards the pending result
        set_ops('0, '0, '0, '0, 32'd2, 32'd2, 4'b0010, 32'd4);
        cycle(2'b10, 2'b00, 2'b10, 2'b00);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        chk("full_before_reset", DW'(bus.rsp_valid), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rsp_valid", DW'(bus.rsp_valid), 32'd0);
        chk("async_rsp_data", bus.rsp_data, 32'd0);
        chk("async_req_ready", DW'(bus.req_ready), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_ops(32'd1, 32'd1, 4'b0010, 32'd2, 32'd10, 32'd3, 4'b0110, 32'd7);
        cycle(2'b11, 2'b11, 2'b01, 2'b00);
        cycle(2'b00, 2'b11, 2'b00, 2'b01);
        cycle(2'b00, 2'b11, 2'b00, 2'b00);

        chk("queue_empty", DW'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
